// File: rtl/key_counter_4bit.sv
// ---------------------------------------------------------------------------
// key_counter_4bit
//
// Purpose:
//   Front end of the 4-bit binary-to-decimal display path. Three active-low
//   pushbuttons (up, down, load) are synchronised and debounced. The
//   resulting press events step a 4-bit binary count up or down, or load it
//   from the slide switches. The count then feeds the display decoder in
//   place of raw switches.
//
// Ports:
//   CLOCK_50  in   1  system clock, all state changes on the rising edge
//   RESET     in   1  synchronous active-high reset
//   KEY       in   3  raw active-low buttons: [0]=up, [1]=down, [2]=load
//   SW        in   4  value taken by an accepted load press
//   count     out  4  current binary value 0..15
//   upd       out  1  one-cycle pulse aligned with each new count value
//   LEDR      out  3  debounced key state, active-high (1 = held)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a key level change counts
//   CNT_W            width of each per-key debounce counter
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// key_debounce
//
// Purpose:
//   One debouncer per key. It tracks an accepted (stable) level. A new
//   level is accepted only after it has differed from the stable level for
//   DEBOUNCE_CYCLES consecutive cycles. A press pulse is emitted when the
//   stable level falls.
//
// Ports:
//   clk_i     in   1  clock
//   rst_i     in   1  synchronous active-high reset
//   sync_i    in   1  synchronised raw key level (active-low)
//   stable_o  out  1  accepted key level (1 = released)
//   press_o   out  1  one-cycle pulse in the cycle the stable level falls
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic stable_o,
    output logic press_o
);

    // The counter value reached just before a flip. When the counter sits
    // here and the input still disagrees, this is the DEBOUNCE_CYCLES-th
    // disagreeing cycle.
    localparam logic [CNT_W-1:0] LastCount = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Next-state logic.
    // Agreement with the stable level clears the counter. This also makes
    // any bounce back restart the qualification from zero.
    // The flip and the press pulse are registered together, so the pulse
    // is high in the same cycle the new stable level is visible.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_i != stable_q) begin
            if (cnt_q == LastCount) begin
                stable_d = sync_i;
                press_d  = ~sync_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers. Reset returns the key to released and discards any
    // qualification in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

module key_counter_4bit #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [2:0] KEY,
    input  logic [3:0] SW,
    output logic [3:0] count,
    output logic       upd,
    output logic [2:0] LEDR
);

    localparam int KeyUp   = 0;
    localparam int KeyDown = 1;
    localparam int KeyLoad = 2;

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] stable;
    logic [2:0] press;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       upd_q;
    logic       upd_d;

    // Two-flop synchroniser for the asynchronous button pins.
    // Reset parks both stages at released. A key that is still held when
    // reset drops therefore propagates through the synchroniser again
    // before its debounce starts.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    // One independent debouncer per key.
    for (genvar i = 0; i < 3; i++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk_i    (CLOCK_50),
            .rst_i    (RESET),
            .sync_i   (sync2_q[i]),
            .stable_o (stable[i]),
            .press_o  (press[i])
        );
    end

    // Count update rules, evaluated on the press pulses.
    // Load beats everything. Simultaneous up and down cancel out with no
    // update pulse. Up and down wrap naturally in 4-bit arithmetic.
    always_comb begin
        count_d = count_q;
        upd_d   = 1'b0;
        if (press[KeyLoad]) begin
            count_d = SW;
            upd_d   = 1'b1;
        end else if (press[KeyUp] && press[KeyDown]) begin
            count_d = count_q;
            upd_d   = 1'b0;
        end else if (press[KeyUp]) begin
            count_d = count_q + 4'd1;
            upd_d   = 1'b1;
        end else if (press[KeyDown]) begin
            count_d = count_q - 4'd1;
            upd_d   = 1'b1;
        end
    end

    // Count and update-pulse registers. upd is registered alongside count,
    // so it is high exactly in the cycle the new value appears.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            count_q <= 4'd0;
            upd_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            upd_q   <= upd_d;
        end
    end

    assign count = count_q;
    assign upd   = upd_q;
    // The debounced levels are already registered, so the LEDs invert them
    // directly to add no extra delay.
    assign LEDR  = ~stable;

endmodule

// File: tb/tb_key_counter_4bit.sv
// ---------------------------------------------------------------------------
// tb_key_counter_4bit
//
// Purpose:
//   Directed bench for key_counter_4bit with a short debounce window.
//   Expected count values are queued when a press is driven. Every upd
//   pulse pops one entry and compares it with the count. In cycles without
//   upd, the count must equal the bench's own model value.
// ---------------------------------------------------------------------------
module tb_key_counter_4bit;

    localparam int Deb = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [2:0] KEY;
    logic [3:0] SW;
    logic [3:0] count;
    logic       upd;
    logic [2:0] LEDR;

    int         testsRun  = 0;
    int         failCount = 0;
    int         updSeen   = 0;
    int         base;
    logic [3:0] expQ[$];
    logic [3:0] model = 4'd0;
    logic [3:0] cur   = 4'd0;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_counter_4bit #(
        .DEBOUNCE_CYCLES (Deb),
        .CNT_W           (24)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY      (KEY),
        .SW       (SW),
        .count    (count),
        .upd      (upd),
        .LEDR     (LEDR)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change only right after a falling edge.
    task automatic applyStimulus(input logic rst, input logic [2:0] key, input logic [3:0] sw);
        RESET = rst;
        KEY   = key;
        SW    = sw;
    endtask

    // Advance one clock and run the scoreboard on the falling edge.
    task automatic tick();
        logic       rstAtEdge;
        logic [3:0] e;
        rstAtEdge = RESET;
        @(negedge CLOCK_50);
        if (rstAtEdge) begin
            model = 4'd0;
        end else if (upd === 1'b1) begin
            updSeen++;
            if (expQ.size() == 0) begin
                checkOutput("spurious_upd_queue_size", 8'(expQ.size()), 8'd1);
            end else begin
                e = expQ.pop_front();
                model = e;
                checkOutput("scoreboard_count", {4'h0, count}, {4'h0, e});
            end
        end else begin
            checkOutput("count_hold", {4'h0, count}, {4'h0, model});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Press key k cleanly, expect the new value 7 cycles after the pin edge,
    // then release and let the debouncer settle.
    task automatic pressKey(input int k, input logic [3:0] expVal);
        logic [2:0] m;
        m = 3'b111;
        m[k] = 1'b0;
        applyStimulus(1'b0, m, SW);
        expQ.push_back(expVal);
        ticks(6);
        checkOutput("press_not_early", {4'h0, count}, {4'h0, cur});
        tick();
        checkOutput("press_upd", {7'h0, upd}, 8'd1);
        checkOutput("press_count", {4'h0, count}, {4'h0, expVal});
        cur = expVal;
        applyStimulus(1'b0, 3'b111, SW);
        ticks(8);
    endtask

    initial begin
        // Reset with all keys released.
        applyStimulus(1'b1, 3'b111, 4'h0);
        ticks(3);
        checkOutput("rst_count", {4'h0, count}, 8'd0);
        checkOutput("rst_upd", {7'h0, upd}, 8'd0);
        checkOutput("rst_ledr", {5'h0, LEDR}, 8'd0);
        applyStimulus(1'b0, 3'b111, 4'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle_ledr", {5'h0, LEDR}, 8'd0);
            checkOutput("idle_upd", {7'h0, upd}, 8'd0);
        end

        // Clean up press held 10 cycles.
        applyStimulus(1'b0, 3'b110, 4'h0);
        expQ.push_back(4'd1);
        ticks(5);
        checkOutput("up_ledr_before", {5'h0, LEDR}, 8'd0);
        tick();
        checkOutput("up_ledr_after", {5'h0, LEDR}, 8'b001);
        checkOutput("up_count_cycle6", {4'h0, count}, 8'd0);
        tick();
        checkOutput("up_upd_cycle7", {7'h0, upd}, 8'd1);
        checkOutput("up_count_cycle7", {4'h0, count}, 8'd1);
        tick();
        checkOutput("up_upd_one_cycle", {7'h0, upd}, 8'd0);
        ticks(2);
        applyStimulus(1'b0, 3'b111, 4'h0);
        ticks(6);
        checkOutput("release_ledr", {5'h0, LEDR}, 8'd0);
        ticks(4);
        checkOutput("release_count", {4'h0, count}, 8'd1);
        cur = 4'd1;

        // Down to 0, down wraps to 15, then 16 ups come back to 15.
        pressKey(1, 4'd0);
        pressKey(1, 4'd15);
        base = updSeen;
        for (int i = 0; i < 16; i++) pressKey(0, cur + 4'd1);
        checkOutput("up16_pulses", 8'(updSeen - base), 8'd16);
        checkOutput("up16_count", {4'h0, count}, 8'd15);

        // Bouncing up key: 0,1,0,1 for 2 cycles each, then held low 6 cycles.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 3'b110, SW);
            ticks(2);
            applyStimulus(1'b0, 3'b111, SW);
            ticks(2);
        end
        checkOutput("bounce_no_step", {4'h0, count}, 8'd15);
        applyStimulus(1'b0, 3'b110, SW);
        expQ.push_back(4'd0);
        ticks(6);
        checkOutput("bounce_count_cycle6", {4'h0, count}, 8'd15);
        applyStimulus(1'b0, 3'b111, SW);
        tick();
        checkOutput("bounce_upd_cycle7", {7'h0, upd}, 8'd1);
        checkOutput("bounce_count_cycle7", {4'h0, count}, 8'd0);
        ticks(8);
        cur = 4'd0;

        // Load and up pressed together: load wins.
        applyStimulus(1'b0, 3'b010, 4'b1001);
        expQ.push_back(4'd9);
        ticks(6);
        checkOutput("load_ledr", {5'h0, LEDR}, 8'b101);
        checkOutput("load_count_cycle6", {4'h0, count}, 8'd0);
        tick();
        checkOutput("load_upd", {7'h0, upd}, 8'd1);
        checkOutput("load_count", {4'h0, count}, 8'd9);
        applyStimulus(1'b0, 3'b111, 4'b1001);
        ticks(8);
        cur = 4'd9;

        // Loading the value already held still pulses upd.
        pressKey(2, 4'd9);

        // Up and down with identical edges cancel.
        applyStimulus(1'b0, 3'b100, 4'b1001);
        ticks(6);
        checkOutput("cancel_ledr", {5'h0, LEDR}, 8'b011);
        tick();
        checkOutput("cancel_upd", {7'h0, upd}, 8'd0);
        checkOutput("cancel_count", {4'h0, count}, 8'd9);
        applyStimulus(1'b0, 3'b111, 4'b1001);
        ticks(8);
        checkOutput("cancel_count_after", {4'h0, count}, 8'd9);

        // Reset 2 cycles into an up press, key kept held. After reset the
        // key passes the released synchroniser again and is debounced again.
        applyStimulus(1'b0, 3'b110, 4'b1001);
        ticks(2);
        applyStimulus(1'b1, 3'b110, 4'b1001);
        tick();
        checkOutput("midrst_count", {4'h0, count}, 8'd0);
        checkOutput("midrst_ledr", {5'h0, LEDR}, 8'd0);
        checkOutput("midrst_upd", {7'h0, upd}, 8'd0);
        applyStimulus(1'b0, 3'b110, 4'b1001);
        expQ.push_back(4'd1);
        ticks(6);
        checkOutput("midrst_count_cycle6", {4'h0, count}, 8'd0);
        tick();
        checkOutput("midrst_upd_cycle7", {7'h0, upd}, 8'd1);
        checkOutput("midrst_count_cycle7", {4'h0, count}, 8'd1);
        applyStimulus(1'b0, 3'b111, 4'b1001);
        ticks(8);

        checkOutput("scoreboard_drained", 8'(expQ.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
